// File: rtl/axi_st_patchkr_pkg.sv
// -----------------------------------------------------------------------------
// axi_st_patchkr_pkg
// Shared types and constants for the N-beat AXI-ST pattern checker:
//   - state_t      : checker FSM states (IDLE, RUN, DONE)
//   - OUT_*        : patchkr_out result codes
//   - slot_width() : width of a slot index for a given beats-per-word ratio
// -----------------------------------------------------------------------------
package axi_st_patchkr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OUT_NONE = 2'b00;
    localparam logic [1:0] OUT_TOUT = 2'b01;
    localparam logic [1:0] OUT_FAIL = 2'b10;
    localparam logic [1:0] OUT_PASS = 2'b11;

    // A slot index is at least one bit wide so RATIO=1 still has a legal port.
    function automatic int slot_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/axi_st_patchkr_sfifo.sv
// -----------------------------------------------------------------------------
// axi_st_patchkr_sfifo
// Single-clock first-word-fall-through FIFO holding expected words.
//   rdclk, rst_n : clock and synchronous active-low reset
//   flush        : empties the FIFO; a write in the same cycle is dropped
//   wr_en, din   : push; dropped while full unless a pop happens that cycle
//   rd_en        : pop of the head entry (ignored while empty)
//   dout         : head entry, valid whenever empty is low
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module axi_st_patchkr_sfifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 64
) (
    input  logic             rdclk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign do_rd = rd_en & ~empty;
    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign do_wr = wr_en & (~full | do_rd);
    assign dout  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    // NOTE: storage has no reset; pointers and count alone define what is valid.
    always_ff @(posedge rdclk) begin
        if (do_wr && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_st_patchkr_nbeat.sv
// -----------------------------------------------------------------------------
// axi_st_patchkr_nbeat
// Receive-side AXI-ST pattern checker. Assembles RATIO narrow beats into one
// FULL_W word (first beat of a run lands at align_slot, lower slots zero),
// compares every word with the next expected word from an internal FWFT FIFO
// and reports pass / fail / timeout with a saturating error count.
//
// Ports:
//   rdclk, rst_n        : clock, synchronous active-low reset
//   patchkr_en          : level; rising edge starts a run, falling edge aborts
//   exp_cnt, align_slot : words per run and first-beat slot, sampled on start
//   exp_din, exp_din_wr : expected-word push; exp_fifo_full flags a full FIFO
//   axist_valid, axist_rcv_data, axist_tready : beat handshake
//   rcv_word_cnt, err_count : words compared / mismatches (saturating)
//   busy                : high in RUN
//   patchkr_out         : 00 idle/running, 11 pass, 10 fail, 01 timeout
//
// Optional build macro AXIST_PATCHKR_ERRLOG_EN adds first_err_idx,
// first_err_syn and first_err_vld: index and XOR syndrome of the first
// mismatching word of the run.
// -----------------------------------------------------------------------------
module axi_st_patchkr_nbeat
    import axi_st_patchkr_pkg::*;
#(
    parameter int DATA_W      = 256,
    parameter int RATIO       = 2,
    parameter int EXP_DEPTH   = 64,
    parameter int CNT_W       = 9,
    parameter int ERR_W       = 9,
    parameter int TIMEOUT_CYC = 1024,
    localparam int FULL_W     = DATA_W * RATIO,
    localparam int SLOT_W     = slot_width(RATIO)
) (
    input  logic              rdclk,
    input  logic              rst_n,
    input  logic              patchkr_en,
    input  logic [CNT_W-1:0]  exp_cnt,
    input  logic [SLOT_W-1:0] align_slot,
    input  logic [FULL_W-1:0] exp_din,
    input  logic              exp_din_wr,
    output logic              exp_fifo_full,
    input  logic              axist_valid,
    input  logic [DATA_W-1:0] axist_rcv_data,
    output logic              axist_tready,
    output logic [CNT_W-1:0]  rcv_word_cnt,
    output logic [ERR_W-1:0]  err_count,
    output logic              busy,
`ifdef AXIST_PATCHKR_ERRLOG_EN
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [FULL_W-1:0] first_err_syn,
    output logic              first_err_vld,
`endif
    output logic [1:0]        patchkr_out
);

    localparam int WD_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    state_t            state_nxt;
    logic              en_r;
    logic              en_d;
    logic              start;
    logic              abort;
    logic [SLOT_W-1:0] slot;
    logic [FULL_W-1:0] word;
    logic              word_pend;
    logic [CNT_W-1:0]  exp_cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [WD_W-1:0]   wd_cnt;
    logic [1:0]        out_q;
    logic [FULL_W-1:0] exp_head;
    logic              fifo_empty;
    logic              accept;
    logic              compare;
    logic              mismatch;
    logic              last_word;
    logic              timeout;
    logic              run_end;

    assign start        = en_r & ~en_d;
    assign abort        = ~en_r & en_d;
    assign busy         = (state == RUN);
    assign axist_tready = (state == RUN) & ~word_pend;
    assign accept       = axist_valid & axist_tready;
    // Abort wins over everything in the same cycle, so no pop happens then.
    assign compare      = (state == RUN) & word_pend & ~fifo_empty & ~abort;
    assign mismatch     = (word != exp_head);
    assign cnt_inc      = rcv_word_cnt + 1'b1;
    assign last_word    = compare & (cnt_inc == exp_cnt_q);
    assign run_end      = (state == RUN) & ~abort & (last_word | timeout);
    assign patchkr_out  = out_q;

    generate
        if (TIMEOUT_CYC > 0) begin : g_wdog
            // wd_cnt holds the idle cycles already seen, so this cycle is the TIMEOUT_CYC-th.
            assign timeout = (state == RUN) & ~abort & ~accept & ~compare &
                             (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
        end else begin : g_no_wdog
            assign timeout = 1'b0;
        end
    endgenerate

    axi_st_patchkr_sfifo #(
        .WIDTH (FULL_W),
        .DEPTH (EXP_DEPTH)
    ) u_exp_fifo (
        .rdclk (rdclk),
        .rst_n (rst_n),
        .flush (run_end),
        .wr_en (exp_din_wr),
        .din   (exp_din),
        .rd_en (compare),
        .dout  (exp_head),
        .full  (exp_fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge rdclk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start)      state_nxt = (exp_cnt == '0) ? DONE : RUN;
                else if (abort) state_nxt = IDLE;
            end
            RUN: begin
                if (abort)        state_nxt = IDLE;
                else if (run_end) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            en_r         <= 1'b0;
            en_d         <= 1'b0;
            slot         <= '0;
            word         <= '0;
            word_pend    <= 1'b0;
            exp_cnt_q    <= '0;
            wd_cnt       <= '0;
            out_q        <= OUT_NONE;
            rcv_word_cnt <= '0;
            err_count    <= '0;
        end else begin
            en_r <= patchkr_en;
            en_d <= en_r;
            if (start && state != RUN) begin
                err_count    <= '0;
                rcv_word_cnt <= '0;
                wd_cnt       <= '0;
                word         <= '0;
                word_pend    <= 1'b0;
                slot         <= (RATIO == 1) ? '0 : align_slot;
                exp_cnt_q    <= exp_cnt;
                out_q        <= (exp_cnt == '0) ? OUT_PASS : OUT_NONE;
            end else if (abort) begin
                // Counters hold so the aborted run can still be inspected.
                out_q <= OUT_NONE;
            end else if (state == RUN) begin
                if (accept) begin
                    word[slot*DATA_W +: DATA_W] <= axist_rcv_data;
                    if (slot == SLOT_W'(RATIO - 1)) begin
                        slot      <= '0;
                        word_pend <= 1'b1;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                if (compare) begin
                    word_pend    <= 1'b0;
                    rcv_word_cnt <= cnt_inc;
                    if (mismatch && err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
                end
                wd_cnt <= (accept || compare) ? '0 : wd_cnt + 1'b1;
                if (last_word) begin
                    out_q <= (err_count == '0 && !mismatch) ? OUT_PASS : OUT_FAIL;
                end else if (timeout) begin
                    out_q <= OUT_TOUT;
                end
                if (run_end) begin
                    word      <= '0;
                    word_pend <= 1'b0;
                end
            end
        end
    end

`ifdef AXIST_PATCHKR_ERRLOG_EN
    always_ff @(posedge rdclk) begin
        if (!rst_n || (start && state != RUN)) begin
            first_err_idx <= '0;
            first_err_syn <= '0;
            first_err_vld <= 1'b0;
        end else if (compare && mismatch && !first_err_vld) begin
            first_err_idx <= rcv_word_cnt;
            first_err_syn <= word ^ exp_head;
            first_err_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_st_patchkr_nbeat.sv
`timescale 1ns/1ps
module tb_axi_st_patchkr_nbeat;

    localparam int DW    = 16;
    localparam int R     = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 9;
    localparam int EW    = 2;
    localparam int TO    = 16;
    localparam int FW    = DW * R;
    localparam int SW    = 2;
    localparam int EMAX  = (1 << EW) - 1;

    logic          rdclk = 1'b0;
    logic          rst_n;
    logic          patchkr_en;
    logic [CW-1:0] exp_cnt;
    logic [SW-1:0] align_slot;
    logic [FW-1:0] exp_din;
    logic          exp_din_wr;
    logic          exp_fifo_full;
    logic          axist_valid;
    logic [DW-1:0] axist_rcv_data;
    logic          axist_tready;
    logic [CW-1:0] rcv_word_cnt;
    logic [EW-1:0] err_count;
    logic          busy;
    logic [1:0]    patchkr_out;
`ifdef AXIST_PATCHKR_ERRLOG_EN
    logic [CW-1:0] first_err_idx;
    logic [FW-1:0] first_err_syn;
    logic          first_err_vld;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 rdclk = ~rdclk;

    axi_st_patchkr_nbeat #(
        .DATA_W(DW), .RATIO(R), .EXP_DEPTH(DEPTH),
        .CNT_W(CW), .ERR_W(EW), .TIMEOUT_CYC(TO)
    ) dut (
        .rdclk          (rdclk),
        .rst_n          (rst_n),
        .patchkr_en     (patchkr_en),
        .exp_cnt        (exp_cnt),
        .align_slot     (align_slot),
        .exp_din        (exp_din),
        .exp_din_wr     (exp_din_wr),
        .exp_fifo_full  (exp_fifo_full),
        .axist_valid    (axist_valid),
        .axist_rcv_data (axist_rcv_data),
        .axist_tready   (axist_tready),
        .rcv_word_cnt   (rcv_word_cnt),
        .err_count      (err_count),
        .busy           (busy),
`ifdef AXIST_PATCHKR_ERRLOG_EN
        .first_err_idx  (first_err_idx),
        .first_err_syn  (first_err_syn),
        .first_err_vld  (first_err_vld),
`endif
        .patchkr_out    (patchkr_out)
    );

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge rdclk);
        #1;
    endtask

    task automatic push(input logic [FW-1:0] d);
        exp_din    = d;
        exp_din_wr = 1'b1;
        tick();
        exp_din_wr = 1'b0;
    endtask

    task automatic start_run(input int n, input int align);
        int w;
        align_slot = SW'(align);
        exp_cnt    = CW'(n);
        patchkr_en = 1'b1;
        w = 0;
        while (!busy && w < 6) begin
            tick();
            w++;
        end
        check("start_busy", busy, 1);
    endtask

    task automatic stop_run();
        patchkr_en = 1'b0;
        tick();
        tick();
        check("after_abort_out", patchkr_out, 2'b00);
        check("after_abort_busy", busy, 0);
        tick();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tready"}, axist_tready, 0);
        check({pfx, "_busy"},   busy, 0);
        check({pfx, "_out"},    patchkr_out, 2'b00);
        check({pfx, "_err"},    err_count, 0);
        check({pfx, "_rcv"},    rcv_word_cnt, 0);
        check({pfx, "_full"},   exp_fifo_full, 0);
    endtask

    // One run driven beat by beat. The reference model places beat j at
    // linear position align+j: word (align+j)/R, slot (align+j)%R. Words
    // flagged in bad_mask get their expected value corrupted in slot 1.
    // cut_at >= 0 stops the run once that many words were compared, then
    // aborts it (cut_rst=0) or pulses reset (cut_rst=1).
    task automatic do_run(input int n_words, input int align, input int bad_mask,
                          input int pre, input bit stall, input int cut_at, input bit cut_rst);
        logic [DW-1:0] beats[$];
        logic [FW-1:0] words[$];
        logic [FW-1:0] corr[$];
        logic [FW-1:0] w;
        int nb, bi, pushed, nbad, first_bad, stall_cyc, cyc, r0, lim;
        bit lat_done;
        nb = n_words * R - align;
        for (int k = 0; k < n_words; k++) begin
            w = '0;
            if (bad_mask[k]) w[DW +: DW] = DW'($urandom_range(65535, 1));
            words.push_back('0);
            corr.push_back(w);
        end
        for (int j = 0; j < nb; j++) begin
            int p;
            p = align + j;
            beats.push_back(DW'($urandom));
            w = words[p / R];
            w[(p % R) * DW +: DW] = beats[j];
            words[p / R] = w;
        end
        pushed = 0;
        for (int k = 0; k < pre; k++) begin
            push(words[k] ^ corr[k]);
            pushed++;
        end
        if (pre == DEPTH) begin
            check("fifo_full", exp_fifo_full, 1);
            push(~(words[0] ^ corr[0]));
            check("fifo_full_hold", exp_fifo_full, 1);
        end
        start_run(n_words, align);
        bi = 0; stall_cyc = 0; cyc = 0; lat_done = 0;
        while (busy && cyc < 2000) begin
            if (cut_at >= 0 && int'(rcv_word_cnt) == cut_at && axist_tready) break;
            if (stall && !lat_done && stall_cyc >= 6 && pushed < n_words) begin
                r0 = int'(rcv_word_cnt);
                axist_valid = 1'b0;
                push(words[pushed] ^ corr[pushed]);
                pushed++;
                check("stall_tready_low", axist_tready, 0);
                check("stall_cnt_hold", rcv_word_cnt, r0);
                tick();
                check("stall_cmp_cnt", rcv_word_cnt, r0 + 1);
                check("stall_tready_back", axist_tready, 1);
                check("stall_no_err", err_count, 0);
                lat_done = 1; stall_cyc = 0; cyc += 2;
                continue;
            end
            axist_valid = 1'b0;
            exp_din_wr  = 1'b0;
            if (bi < nb && (stall || $urandom_range(3, 0) != 0)) begin
                axist_valid    = 1'b1;
                axist_rcv_data = beats[bi];
                if (axist_tready) bi++;
            end
            if (pushed < n_words && (!stall || stall_cyc >= 6)) begin
                exp_din    = words[pushed] ^ corr[pushed];
                exp_din_wr = 1'b1;
                pushed++;
                stall_cyc  = 0;
            end else if (stall && !axist_tready) begin
                stall_cyc++;
            end else begin
                stall_cyc = 0;
            end
            tick();
            cyc++;
        end
        axist_valid = 1'b0;
        exp_din_wr  = 1'b0;
        lim = (cut_at >= 0) ? cut_at : n_words;
        nbad = 0; first_bad = -1;
        for (int k = 0; k < lim; k++) begin
            if (bad_mask[k]) begin
                if (first_bad < 0) first_bad = k;
                nbad++;
            end
        end
        if (cut_at >= 0 && cut_rst) begin
            rst_n      = 1'b0;
            patchkr_en = 1'b0;
            tick();
            check_reset_outputs("midrun_rst");
            rst_n = 1'b1;
            tick();
            return;
        end
        if (cut_at >= 0) begin
            check("abort_busy_before", busy, 1);
            patchkr_en = 1'b0;
            tick();
            tick();
            check("abort_busy", busy, 0);
            check("abort_out", patchkr_out, 2'b00);
            check("abort_rcv_hold", rcv_word_cnt, cut_at);
            check("abort_err_hold", err_count, (nbad > EMAX) ? EMAX : nbad);
            tick();
            return;
        end
        check("run_finished", busy, 0);
        check("run_out", patchkr_out, (nbad > 0) ? 2'b10 : 2'b11);
        check("run_err", err_count, (nbad > EMAX) ? EMAX : nbad);
        check("run_rcv", rcv_word_cnt, n_words);
        check("run_fifo_not_full", exp_fifo_full, 0);
`ifdef AXIST_PATCHKR_ERRLOG_EN
        check("errlog_vld", first_err_vld, nbad > 0);
        if (nbad > 0) begin
            check("errlog_idx", first_err_idx, first_bad);
            check("errlog_syn", first_err_syn, corr[first_bad]);
        end
`endif
        stop_run();
    endtask

    initial begin
        int n;
        int saw_busy;
        rst_n = 1'b0; patchkr_en = 1'b0; exp_cnt = '0; align_slot = '0;
        exp_din = '0; exp_din_wr = 1'b0; axist_valid = 1'b0; axist_rcv_data = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Plain pass, then a full FIFO with a dropped extra push, then word 2 corrupted.
        do_run(4, 0, 'b0000, 4, 0, -1, 0);
        do_run(8, 0, 'b0,    8, 0, -1, 0);
        do_run(4, 0, 'b0100, 4, 0, -1, 0);
        // First word starts at slot 2; slots 0-1 must read as zero.
        do_run(3, 2, 'b000,  3, 0, -1, 0);
        // Randomised runs.
        for (int i = 0; i < 4; i++) begin
            n = $urandom_range(6, 1);
            do_run(n, $urandom_range(3, 0), $urandom_range(63, 0), n, 0, -1, 0);
        end
        // Expected FIFO runs dry while a word is pending.
        do_run(3, 0, 'b000, 1, 1, -1, 0);

        // exp_cnt of zero finishes immediately with pass.
        saw_busy = 0;
        exp_cnt = '0;
        patchkr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy) saw_busy = 1;
        end
        check("zero_cnt_never_busy", saw_busy, 0);
        check("zero_cnt_out", patchkr_out, 2'b11);
        stop_run();

        // Watchdog: full FIFO, no beats; the run must last exactly TO cycles.
        for (int k = 0; k < DEPTH; k++) push(FW'({$urandom, $urandom}));
        check("tout_fifo_full", exp_fifo_full, 1);
        start_run(4, 0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check("tout_cycles", n, TO);
        check("tout_out", patchkr_out, 2'b01);
        check("tout_fifo_flushed", exp_fifo_full, 0);
        stop_run();
        // Stale entries would make this run fail.
        do_run(2, 1, 'b00, 2, 0, -1, 0);

        // Saturation of a 2-bit error counter.
        do_run(5, 0, 'b11111, 5, 0, -1, 0);
        // Abort after two words, then reset in the middle of a run.
        do_run(4, 0, 'b0001, 4, 0, 2, 0);
        do_run(4, 0, 'b0011, 4, 0, 1, 1);
        do_run(3, 1, 'b010, 3, 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
